// File: rtl/xorpkt_pkg.sv
// Shared definitions for the running-XOR packet transmitter.
//   state_t    : transmitter FSM encoding (3 bits, exported on the debug port)
//   DWIDTH     : default byte width
//   xor_reduce : XOR of the first n bytes of a packed byte vector (byte 0 in
//                the least significant lane), used to build expected results
package xorpkt_pkg;

  localparam int unsigned DWIDTH = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    EXP  = 3'd3
  } state_t;

  function automatic logic [DWIDTH-1:0] xor_reduce(input logic [8*DWIDTH-1:0] bytes,
                                                   input int unsigned n);
    logic [DWIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < n) r = r ^ bytes[i*DWIDTH +: DWIDTH];
    end
    return r;
  endfunction

endpackage

// File: rtl/xorpkt_tx.sv
// Running-XOR packet transmitter. Each accepted length command produces one
// count byte followed by that many data bytes (pulled from the source fifo)
// into the output fifo, then pushes the XOR of the data bytes into the
// expected-result fifo.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/cmd_len/cmd_ready   length command handshake (IDLE only)
//   ififo_rdy/idata/ififo_pop     show-ahead data source fifo
//   ofifo_not_full/ofifo_push/odata   output byte stream
//   exp_not_full/exp_push/exp_data    expected XOR result
//   err_len0                  one-cycle pulse when a zero-length command is dropped
//   tx_idle, state            status / debug
module xorpkt_tx
  import xorpkt_pkg::*;
#(
  parameter int unsigned dwidth = DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [dwidth-1:0] cmd_len,
  output logic              cmd_ready,
  input  logic              ififo_rdy,
  input  logic [dwidth-1:0] idata,
  output logic              ififo_pop,
  input  logic              ofifo_not_full,
  output logic              ofifo_push,
  output logic [dwidth-1:0] odata,
  input  logic              exp_not_full,
  output logic              exp_push,
  output logic [dwidth-1:0] exp_data,
  output logic              err_len0,
  output logic              tx_idle,
  output logic [2:0]        state
);

  state_t            state_q, state_d;
  logic [dwidth-1:0] rem_cnt_q, rem_cnt_d;
  logic [dwidth-1:0] acc_q, acc_d;
  logic              err_len0_q, err_len0_d;
  logic              xfer;

  // A data beat moves only when both source and sink are ready, so pop and
  // push are always paired.
  assign xfer = ififo_rdy & ofifo_not_full;

  always_comb begin
    state_d    = state_q;
    rem_cnt_d  = rem_cnt_q;
    acc_d      = acc_q;
    err_len0_d = 1'b0;
    cmd_ready  = 1'b0;
    ififo_pop  = 1'b0;
    ofifo_push = 1'b0;
    exp_push   = 1'b0;
    odata      = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            rem_cnt_d = cmd_len;
            acc_d     = '0;
            state_d   = HDR;
          end else begin
            err_len0_d = 1'b1;
          end
        end
      end
      HDR: begin
        odata = rem_cnt_q;
        if (ofifo_not_full) begin
          ofifo_push = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        odata = idata;
        if (xfer) begin
          ififo_pop  = 1'b1;
          ofifo_push = 1'b1;
          acc_d      = acc_q ^ idata;
          rem_cnt_d  = rem_cnt_q - dwidth'(1);
          if (rem_cnt_q == dwidth'(1)) state_d = EXP;
        end
      end
      EXP: begin
        if (exp_not_full) begin
          exp_push = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rem_cnt_q  <= '0;
      acc_q      <= '0;
      err_len0_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_cnt_q  <= rem_cnt_d;
      acc_q      <= acc_d;
      err_len0_q <= err_len0_d;
    end
  end

  assign exp_data = acc_q;
  assign err_len0 = err_len0_q;
  assign tx_idle  = (state_q == IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_xorpkt_tx.sv
// Directed self-checking bench for xorpkt_tx. Inputs change on the falling
// edge; combinational outputs are sampled 1ns later and pushes/pops are logged.
module tb_xorpkt_tx;
  import xorpkt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = 8'h00;
  logic       cmd_ready;
  logic       ififo_rdy = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       ififo_pop;
  logic       ofifo_not_full = 1'b1;
  logic       ofifo_push;
  logic [7:0] odata;
  logic       exp_not_full = 1'b1;
  logic       exp_push;
  logic [7:0] exp_data;
  logic       err_len0;
  logic       tx_idle;
  logic [2:0] state;

  xorpkt_tx #(.dwidth(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_len       (cmd_len),
    .cmd_ready     (cmd_ready),
    .ififo_rdy     (ififo_rdy),
    .idata         (idata),
    .ififo_pop     (ififo_pop),
    .ofifo_not_full(ofifo_not_full),
    .ofifo_push    (ofifo_push),
    .odata         (odata),
    .exp_not_full  (exp_not_full),
    .exp_push      (exp_push),
    .exp_data      (exp_data),
    .err_len0      (err_len0),
    .tx_idle       (tx_idle),
    .state         (state)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  int         pops = 0;
  logic       src_en = 1'b1;
  logic [7:0] src_q[$];
  logic [7:0] obytes[$];
  int         ocyc[$];
  logic [7:0] ebytes[$];
  int         ecyc[$];
  int         acc_cyc[$];

  task automatic clear_log();
    obytes.delete(); ocyc.delete(); ebytes.delete(); ecyc.delete(); acc_cyc.delete();
    pops = 0;
  endtask

  // One clock: drive the source model, sample and log, advance to next negedge.
  task automatic step();
    ififo_rdy = src_en && (src_q.size() > 0);
    idata     = (src_q.size() > 0) ? src_q[0] : 8'h00;
    #1;
    if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
    if (ofifo_push) begin obytes.push_back(odata); ocyc.push_back(cyc); end
    if (exp_push) begin ebytes.push_back(exp_data); ecyc.push_back(cyc); end
    if (ififo_pop) begin
      pops++;
      if (src_q.size() > 0) src_q.delete(0);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    int n0;
    n0 = acc_cyc.size();
    cmd_valid = 1'b1;
    cmd_len   = len;
    for (int k = 0; k < 20 && acc_cyc.size() == n0; k++) step();
    cmd_valid = 1'b0;
    total++;
    if (acc_cyc.size() == n0) $display("FAIL cmd_accept len=%0d: got no acceptance, need one", len);
    else passed++;
  endtask

  task automatic wait_exp(input int n);
    for (int k = 0; k < 600 && ebytes.size() < n; k++) step();
    total++;
    if (ebytes.size() < n) $display("FAIL exp_timeout: got %0d exp pushes, need %0d", ebytes.size(), n);
    else passed++;
  endtask

  task automatic check_stream(input string name, input logic [7:0] want[$]);
    logic [7:0] got;
    total++;
    if (obytes.size() != want.size()) begin
      $display("FAIL %s_len: got %0d bytes, need %0d", name, obytes.size(), want.size());
    end else passed++;
    for (int i = 0; i < want.size(); i++) begin
      got = (i < obytes.size()) ? obytes[i] : 8'hxx;
      total++;
      if (got !== want[i]) $display("FAIL %s_byte%0d: got %h, need %h", name, i, got, want[i]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({state, cmd_ready, tx_idle, ofifo_push, ififo_pop, exp_push, err_len0} !== 9'b000_110000)
      $display("FAIL reset_outputs: got st=%0d rdy=%b idle=%b push=%b pop=%b exp=%b err=%b, need st=0 rdy=1 idle=1 others 0",
               state, cmd_ready, tx_idle, ofifo_push, ififo_pop, exp_push, err_len0);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    clear_log();
    src_q = '{8'h16, 8'h05, 8'h08, 8'hFF};
    send_cmd(8'd4);
    wait_exp(1);
    check_stream("single", '{8'h04, 8'h16, 8'h05, 8'h08, 8'hFF});
    total++;
    if (ocyc.size() == 5 && ocyc[4] - ocyc[0] == 4) passed++;
    else $display("FAIL single_consecutive: got span %0d, need 4", (ocyc.size() == 5) ? ocyc[4] - ocyc[0] : -1);
    total++;
    if (ebytes[0] !== 8'hE4) $display("FAIL single_exp: got %h, need e4", ebytes[0]);
    else passed++;
    #1;
    total++;
    if (tx_idle !== 1'b1) $display("FAIL single_back_idle: got tx_idle %b, need 1", tx_idle);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    clear_log();
    src_q = '{8'h16, 8'h05, 8'h08, 8'hFF, 8'h44, 8'h76, 8'h65};
    cmd_valid = 1'b1;
    cmd_len = 8'd4;
    for (int k = 0; k < 20 && acc_cyc.size() < 1; k++) step();
    cmd_len = 8'd3;  // held valid; ignored until the transmitter returns to IDLE
    for (int k = 0; k < 20 && acc_cyc.size() < 2; k++) step();
    cmd_valid = 1'b0;
    wait_exp(2);
    check_stream("b2b", '{8'h04, 8'h16, 8'h05, 8'h08, 8'hFF, 8'h03, 8'h44, 8'h76, 8'h65});
    total++;
    if (ebytes[0] !== 8'hE4 || ebytes[1] !== 8'h57)
      $display("FAIL b2b_exp: got %h %h, need e4 57", ebytes[0], ebytes[1]);
    else passed++;
    total++;
    if (acc_cyc.size() == 2 && acc_cyc[1] == ecyc[0] + 1) passed++;
    else $display("FAIL b2b_accept_gap: got accept cycle %0d, need %0d",
                  (acc_cyc.size() == 2) ? acc_cyc[1] : -1, ecyc[0] + 1);
    total++;
    if (ocyc.size() == 9 && ocyc[5] == ocyc[4] + 3) passed++;
    else $display("FAIL b2b_hdr_gap: got %0d, need 3", (ocyc.size() == 9) ? ocyc[5] - ocyc[4] : -1);
    step();
  endtask

  task automatic test_len1_len0();
    clear_log();
    src_q = '{8'hA5};
    send_cmd(8'd1);
    wait_exp(1);
    check_stream("len1", '{8'h01, 8'hA5});
    total++;
    if (ebytes[0] !== 8'hA5) $display("FAIL len1_exp: got %h, need a5", ebytes[0]);
    else passed++;
    step();
    clear_log();
    send_cmd(8'd0);
    #1;
    total++;
    if (err_len0 !== 1'b1 || tx_idle !== 1'b1 || state !== 3'd0)
      $display("FAIL len0_pulse: got err=%b idle=%b st=%0d, need err=1 idle=1 st=0", err_len0, tx_idle, state);
    else passed++;
    step();
    #1;
    total++;
    if (err_len0 !== 1'b0) $display("FAIL len0_pulse_width: got err=%b, need 0", err_len0);
    else passed++;
    step();
    total++;
    if (obytes.size() != 0 || pops != 0 || ebytes.size() != 0)
      $display("FAIL len0_nopush: got pushes=%0d pops=%0d exps=%0d, need 0 0 0", obytes.size(), pops, ebytes.size());
    else passed++;
  endtask

  task automatic test_stall();
    int nb, np;
    clear_log();
    src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_cmd(8'd6);
    for (int k = 0; k < 20 && obytes.size() < 3; k++) step();
    nb = obytes.size();
    np = pops;
    ofifo_not_full = 1'b0;
    repeat (3) step();
    ofifo_not_full = 1'b1;
    src_en = 1'b0;
    repeat (2) step();
    src_en = 1'b1;
    total++;
    if (obytes.size() != nb || pops != np)
      $display("FAIL stall_hold: got pushes=%0d pops=%0d, need %0d %0d", obytes.size(), pops, nb, np);
    else passed++;
    wait_exp(1);
    check_stream("stall", '{8'h06, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6});
    total++;
    if (pops != 6) $display("FAIL stall_pops: got %0d, need 6", pops);
    else passed++;
    total++;
    if (ebytes[0] !== 8'h07) $display("FAIL stall_exp: got %h, need 07", ebytes[0]);
    else passed++;
    step();
  endtask

  task automatic test_exp_hold();
    clear_log();
    src_q = '{8'h0F, 8'hF0};
    exp_not_full = 1'b0;
    send_cmd(8'd2);
    for (int k = 0; k < 20 && ocyc.size() < 3; k++) step();
    cmd_valid = 1'b1;  // must be ignored while in EXP
    cmd_len = 8'd5;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (state !== 3'd3 || cmd_ready !== 1'b0 || exp_push !== 1'b0)
        $display("FAIL exp_hold%0d: got st=%0d rdy=%b push=%b, need st=3 rdy=0 push=0", i, state, cmd_ready, exp_push);
      else passed++;
      step();
    end
    cmd_valid = 1'b0;
    exp_not_full = 1'b1;
    wait_exp(1);
    repeat (3) step();
    total++;
    if (ebytes.size() != 1 || ebytes[0] !== 8'hFF || acc_cyc.size() != 1)
      $display("FAIL exp_release: got exps=%0d val=%h accepts=%0d, need 1 ff 1", ebytes.size(), ebytes[0], acc_cyc.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] pk;
    clear_log();
    for (int i = 0; i < 300; i++) src_q.push_back(8'(i));
    send_cmd(8'd255);
    for (int k = 0; k < 40 && obytes.size() < 10; k++) step();
    rst = 1'b0;
    #1;
    total++;
    if ({state, tx_idle, cmd_ready, ofifo_push, ififo_pop, exp_push} !== 8'b000_11000)
      $display("FAIL rst_mid: got st=%0d idle=%b rdy=%b push=%b pop=%b exp=%b, need st=0 idle=1 rdy=1 others 0",
               state, tx_idle, cmd_ready, ofifo_push, ififo_pop, exp_push);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    src_q.delete();
    clear_log();
    @(negedge clk);
    src_q = '{8'h11, 8'h22};
    send_cmd(8'd2);
    wait_exp(1);
    check_stream("post_rst", '{8'h02, 8'h11, 8'h22});
    pk = 64'h2211;
    total++;
    if (ebytes[0] !== 8'h33 || ebytes[0] !== xor_reduce(pk, 2))
      $display("FAIL post_rst_exp: got %h, need 33", ebytes[0]);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_len1_len0();
    test_stall();
    test_exp_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xorpkt_tx.md
Name: xorpkt_tx

Overview:
Packet transmitter for the running-XOR byte-stream protocol. For each accepted length command it emits one count byte followed by that many data bytes, pulled from a data source fifo, into the output fifo that feeds the XOR executor's input fifo. It also pushes the XOR of the emitted data bytes into an expected-result fifo, which a scoreboard compares against the executor's output.

Parameters:
dwidth, 8, width of data, count and XOR bytes; the count field is dwidth bits.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset; low clears all state immediately
cmd_valid  in  1  length command present
cmd_len  in  dwidth  number of data bytes in the packet
cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
ififo_rdy  in  1  data source fifo non-empty; idata valid (show-ahead head)
idata  in  dwidth  head of data source fifo
ififo_pop  out  1  pop the data source head at this clock edge
ofifo_not_full  in  1  output fifo can accept a byte this cycle
ofifo_push  out  1  write odata into the output fifo at this edge
odata  out  dwidth  byte written to the output fifo
exp_not_full  in  1  expected-result fifo can accept
exp_push  out  1  write exp_data at this edge
exp_data  out  dwidth  XOR of the packet's data bytes
err_len0  out  1  one-cycle pulse: zero-length command dropped
tx_idle  out  1  high when state is IDLE
state  out  3  current FSM state, for debug and formal

Behaviour:
- States: IDLE=0, HDR=1, DATA=2, EXP=3.
- Reset (rst low, async): state=IDLE, rem_cnt=0, acc=0, err_len0=0.
  - Combinational outputs evaluate to push/pop=0, cmd_ready=1, tx_idle=1.
  - Reset mid-packet abandons the packet. Downstream fifos are reset by the same rst.
- Push and pop outputs are combinational from registered state plus the same-cycle handshake inputs. odata is combinational from state, rem_cnt, acc and idata.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_len!=0: rem_cnt<=cmd_len, acc<=0, go to HDR.
  - On cmd_valid with cmd_len==0: command consumed, err_len0<=1 next cycle, stay in IDLE, nothing pushed.
- HDR:
  - cmd_ready=0.
  - If ofifo_not_full: ofifo_push=1, odata=rem_cnt, go to DATA.
  - Otherwise hold.
- DATA:
  - Transfer happens only when ififo_rdy & ofifo_not_full. Then ififo_pop=1, ofifo_push=1, odata=idata, acc<=acc^idata, rem_cnt<=rem_cnt-1.
  - If rem_cnt==1 on a transfer, go to EXP.
  - With no transfer, hold all state. Never pop without pushing, and never push without popping.
- EXP:
  - exp_data=acc.
  - If exp_not_full: exp_push=1, go to IDLE.
  - A new command is accepted only from IDLE, so there is one idle cycle between packets.
- Throughput: header plus N data bytes take N+1 cycles minimum, plus one EXP cycle and one IDLE cycle.
- Arithmetic: the XOR is dwidth wide. rem_cnt is dwidth bits, and cmd_len=2^dwidth-1 (255) is legal.
- cmd_valid asserted outside IDLE is ignored (cmd_ready=0). cmd_len is sampled only on acceptance.
- The count byte is never XORed into acc.

Decomposition:
- Shared package xorpkt_pkg holds:
  - state enum typedef (IDLE, HDR, DATA, EXP, 3 bits);
  - default DWIDTH localparam;
  - helper function xor_reduce for bench use.
- No sub-module: the counter and accumulator are a few lines inside the FSM.

Test Plan:
1. cmd_len=4; source 16,05,08,FF; fifos always ready. Expect ofifo 04,16,05,08,FF on 5 consecutive cycles, then exp_data=E4.
2. Back-to-back commands len 4 then len 3 (data 44,76,65). Expect stream 04,16,05,08,FF,03,44,76,65; exp E4 then 57; second cmd_ready exactly one cycle after the first EXP.
3. cmd_len=1 with data A5 gives 01,A5 and exp A5. cmd_len=0 gives an err_len0 pulse, no push, no pop, tx_idle stays 1.
4. Mid-DATA, drop ofifo_not_full for 3 cycles, then ififo_rdy for 2 cycles. Expect no push or pop during stalls and an unbroken, correct byte order.
5. exp_not_full=0 for 5 cycles in EXP. Expect state held at 3, cmd_ready=0, exp_push once on release.
6. Assert rst low during DATA of a len-255 packet. Expect immediate IDLE with all pushes and pops 0. A following len-2 command (11,22) gives 02,11,22 and exp 33.
